// File: rtl/memory_stage.sv
// MEM stage: issues dmem req/gnt/rvalid transactions, aligns/extends loads, loads MEM/WB.
// Latency: stores 0 hold cycles, loads 1 + gnt/rvalid wait cycles; mem_hold freezes upstream while a memop is pending.
module memory_stage (
    input  logic        clk,
    input  logic        Rst,
    input  logic        dbg,
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    input  logic        EX_MEM_regwrite,
    input  logic [4:0]  EX_MEM_rd,
    input  logic [31:0] EX_MEM_alures,
    input  logic [31:0] EX_MEM_mulres,
    input  logic [31:0] EX_MEM_divres,
    input  logic        EX_MEM_mul_ready,
    input  logic        EX_MEM_div_ready,
    input  logic [31:0] EX_MEM_dout_rs2,
    input  logic [4:0]  EX_MEM_loadcntrl,
    input  logic [2:0]  EX_MEM_storecntrl,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_hold,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regwrite,
    output logic [31:0] WB_res,
    output logic        misalign_exc,
    output logic [31:0] misalign_addr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        memop;
    logic        misal;
    logic        issue;
    logic        req_raw;
    logic        hold_raw;
    logic        misal_fire;
    logic [1:0]  lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] ld_cap;
    logic [31:0] res_sel;

    assign lane  = EX_MEM_alures[1:0];
    assign memop = EX_MEM_memread | EX_MEM_memwrite;

    assign misal = memop &
        (((EX_MEM_loadcntrl[1] | EX_MEM_loadcntrl[4] | EX_MEM_storecntrl[1]) & lane[0]) |
         ((EX_MEM_loadcntrl[2] | EX_MEM_storecntrl[2]) & (lane != 2'b00)));

    assign issue      = (state == IDLE) & memop & !misal & !dbg;
    assign req_raw    = issue | (state == REQ);
    assign misal_fire = (state == IDLE) & misal & !dbg;

    // Request outputs are forced low during reset even if EX/MEM still carries a memop.
    assign dmem_req  = Rst & req_raw;
    assign dmem_we   = dmem_req & EX_MEM_memwrite;
    assign dmem_addr = dmem_req ? {EX_MEM_alures[31:2], 2'b00} : 32'h0;

    always_comb begin
        dmem_be    = 4'h0;
        dmem_wdata = 32'h0;
        if (dmem_req) begin
            if (EX_MEM_memwrite) begin
                if (EX_MEM_storecntrl[0]) begin
                    dmem_be    = 4'b0001 << lane;
                    dmem_wdata = {4{EX_MEM_dout_rs2[7:0]}};
                end else if (EX_MEM_storecntrl[1]) begin
                    dmem_be    = 4'b0011 << {lane[1], 1'b0};
                    dmem_wdata = {2{EX_MEM_dout_rs2[15:0]}};
                end else begin
                    dmem_be    = 4'hF;
                    dmem_wdata = EX_MEM_dout_rs2;
                end
            end else begin
                dmem_be = 4'hF;
            end
        end
    end

    always_comb begin
        hold_raw = 1'b0;
        case (state)
            IDLE:    hold_raw = memop & !misal & !(EX_MEM_memwrite & dmem_gnt & !dbg);
            REQ:     hold_raw = !(EX_MEM_memwrite & dmem_gnt);
            WAIT:    hold_raw = !dmem_rvalid;
            default: hold_raw = 1'b0;
        endcase
    end

    assign mem_hold = Rst & hold_raw;

    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (lane)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld_ext  = dmem_rdata;
        if (EX_MEM_loadcntrl[0])      ld_ext = {{24{ld_byte[7]}}, ld_byte};
        else if (EX_MEM_loadcntrl[1]) ld_ext = {{16{ld_half[15]}}, ld_half};
        else if (EX_MEM_loadcntrl[3]) ld_ext = {24'h0, ld_byte};
        else if (EX_MEM_loadcntrl[4]) ld_ext = {16'h0, ld_half};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) begin
                if (dmem_gnt) state_nxt = EX_MEM_memwrite ? IDLE : WAIT;
                else          state_nxt = REQ;
            end
            REQ: if (dmem_gnt) begin
                if (!EX_MEM_memwrite) state_nxt = WAIT;
                else                  state_nxt = dbg ? DONE : IDLE;
            end
            WAIT: if (dmem_rvalid) state_nxt = dbg ? DONE : IDLE;
            default: if (!dbg) state_nxt = IDLE;
        endcase
    end

    // In DONE the load result comes from the capture register; otherwise straight from rdata.
    always_comb begin
        if (EX_MEM_memread)        res_sel = (state == DONE) ? ld_cap : ld_ext;
        else if (EX_MEM_div_ready) res_sel = EX_MEM_divres;
        else if (EX_MEM_mul_ready) res_sel = EX_MEM_mulres;
        else                       res_sel = EX_MEM_alures;
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state           <= IDLE;
            ld_cap          <= 32'h0;
            MEM_WB_rd       <= 5'h0;
            MEM_WB_regwrite <= 1'b0;
            WB_res          <= 32'h0;
            misalign_exc    <= 1'b0;
            misalign_addr   <= 32'h0;
        end else begin
            state        <= state_nxt;
            misalign_exc <= misal_fire;
            if (misal_fire)
                misalign_addr <= EX_MEM_alures;
            if ((state == WAIT) && dmem_rvalid)
                ld_cap <= ld_ext;
            if (!dbg) begin
                if (hold_raw) begin
                    MEM_WB_regwrite <= 1'b0;
                end else begin
                    MEM_WB_rd       <= EX_MEM_rd;
                    MEM_WB_regwrite <= EX_MEM_regwrite & !misal;
                    WB_res          <= res_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed-vector bench for memory_stage with hand-computed expectations.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        Rst = 1'b0;
    logic        dbg = 1'b0;
    logic        EX_MEM_memread = 1'b0;
    logic        EX_MEM_memwrite = 1'b0;
    logic        EX_MEM_regwrite = 1'b0;
    logic [4:0]  EX_MEM_rd = 5'h0;
    logic [31:0] EX_MEM_alures = 32'h0;
    logic [31:0] EX_MEM_mulres = 32'h0;
    logic [31:0] EX_MEM_divres = 32'h0;
    logic        EX_MEM_mul_ready = 1'b0;
    logic        EX_MEM_div_ready = 1'b0;
    logic [31:0] EX_MEM_dout_rs2 = 32'h0;
    logic [4:0]  EX_MEM_loadcntrl = 5'h0;
    logic [2:0]  EX_MEM_storecntrl = 3'h0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        mem_hold;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_regwrite;
    logic [31:0] WB_res;
    logic        misalign_exc;
    logic [31:0] misalign_addr;

    int total = 0;
    int bad   = 0;
    int req_cnt;
    int hold_cnt;

    memory_stage dut (
        .clk(clk), .Rst(Rst), .dbg(dbg),
        .EX_MEM_memread(EX_MEM_memread), .EX_MEM_memwrite(EX_MEM_memwrite),
        .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_rd(EX_MEM_rd),
        .EX_MEM_alures(EX_MEM_alures), .EX_MEM_mulres(EX_MEM_mulres),
        .EX_MEM_divres(EX_MEM_divres), .EX_MEM_mul_ready(EX_MEM_mul_ready),
        .EX_MEM_div_ready(EX_MEM_div_ready), .EX_MEM_dout_rs2(EX_MEM_dout_rs2),
        .EX_MEM_loadcntrl(EX_MEM_loadcntrl), .EX_MEM_storecntrl(EX_MEM_storecntrl),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .mem_hold(mem_hold),
        .MEM_WB_rd(MEM_WB_rd), .MEM_WB_regwrite(MEM_WB_regwrite), .WB_res(WB_res),
        .misalign_exc(misalign_exc), .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [31:0] alu);
        EX_MEM_memread    = 1'b0;
        EX_MEM_memwrite   = 1'b0;
        EX_MEM_regwrite   = 1'b0;
        EX_MEM_rd         = 5'h0;
        EX_MEM_alures     = alu;
        EX_MEM_mul_ready  = 1'b0;
        EX_MEM_div_ready  = 1'b0;
        EX_MEM_loadcntrl  = 5'h0;
        EX_MEM_storecntrl = 3'h0;
    endtask

    task automatic set_load(input logic [4:0] ctl, input logic [31:0] addr, input logic [4:0] rd);
        nop(addr);
        EX_MEM_memread   = 1'b1;
        EX_MEM_regwrite  = 1'b1;
        EX_MEM_rd        = rd;
        EX_MEM_loadcntrl = ctl;
    endtask

    task automatic set_store(input logic [2:0] ctl, input logic [31:0] addr, input logic [31:0] data);
        nop(addr);
        EX_MEM_memwrite   = 1'b1;
        EX_MEM_storecntrl = ctl;
        EX_MEM_dout_rs2   = data;
    endtask

    // Zero-wait load: gnt in the issue cycle, rvalid the next cycle.
    task automatic load_zw(input string tag, input logic [4:0] ctl, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp_res);
        set_load(ctl, addr, 5'd4);
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk({tag, "_req"},  32'(dmem_req), 32'h1);
        chk({tag, "_addr"}, dmem_addr, exp_addr);
        chk({tag, "_hold"}, 32'(mem_hold), 32'h1);
        step();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(negedge clk);
        chk({tag, "_hold2"}, 32'(mem_hold), 32'h0);
        step();
        dmem_rvalid = 1'b0;
        chk({tag, "_res"}, WB_res, exp_res);
        chk({tag, "_rw"},  32'(MEM_WB_regwrite), 32'h1);
        nop(32'h0);
    endtask

    initial begin
        // Reset state with a load already sitting in EX/MEM.
        set_load(5'b00100, 32'h100, 5'd5);
        #3;
        chk("rst_res",  WB_res, 32'h0);
        chk("rst_rw",   32'(MEM_WB_regwrite), 32'h0);
        chk("rst_rd",   32'(MEM_WB_rd), 32'h0);
        chk("rst_req",  32'(dmem_req), 32'h0);
        chk("rst_hold", 32'(mem_hold), 32'h0);
        chk("rst_exc",  32'(misalign_exc), 32'h0);
        nop(32'h0);
        @(negedge clk);
        Rst = 1'b1;
        step();

        // LW 0x100: one hold cycle, result one edge after rvalid.
        set_load(5'b00100, 32'h100, 5'd5);
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk("lw_req",  32'(dmem_req), 32'h1);
        chk("lw_we",   32'(dmem_we), 32'h0);
        chk("lw_addr", dmem_addr, 32'h100);
        chk("lw_hold", 32'(mem_hold), 32'h1);
        step();
        chk("lw_bubble", 32'(MEM_WB_regwrite), 32'h0);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        chk("lw_hold2", 32'(mem_hold), 32'h0);
        chk("lw_req2",  32'(dmem_req), 32'h0);
        step();
        dmem_rvalid = 1'b0;
        chk("lw_res", WB_res, 32'hDEADBEEF);
        chk("lw_rw",  32'(MEM_WB_regwrite), 32'h1);
        chk("lw_rd",  32'(MEM_WB_rd), 32'd5);
        nop(32'h0);

        load_zw("lb",  5'b00001, 32'h103, 32'h80112233, 32'h100, 32'hFFFFFF80);
        load_zw("lbu", 5'b01000, 32'h103, 32'h80112233, 32'h100, 32'h00000080);
        load_zw("lh",  5'b00010, 32'h102, 32'h80112233, 32'h100, 32'hFFFF8011);
        load_zw("lhu", 5'b10000, 32'h000, 32'h80112233, 32'h000, 32'h00002233);

        // SH at 0x102 with gnt three cycles late.
        set_store(3'b010, 32'h102, 32'h0000ABCD);
        dmem_gnt = 1'b0;
        req_cnt  = 0;
        hold_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_gnt = 1'b1;
            @(negedge clk);
            if (dmem_req) req_cnt++;
            if (mem_hold) hold_cnt++;
            if (i == 0) begin
                chk("sh_be",    32'(dmem_be), 32'hC);
                chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
                chk("sh_we",    32'(dmem_we), 32'h1);
            end
            step();
        end
        dmem_gnt = 1'b0;
        chk("sh_reqcnt",  32'(req_cnt), 32'd4);
        chk("sh_holdcnt", 32'(hold_cnt), 32'd3);
        chk("sh_res",     WB_res, 32'h102);
        chk("sh_rw",      32'(MEM_WB_regwrite), 32'h0);
        nop(32'h0);
        @(negedge clk);
        chk("sh_idle_req", 32'(dmem_req), 32'h0);

        // Zero-wait SB and SW: no hold.
        set_store(3'b001, 32'h101, 32'h1234565A);
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk("sb_be",    32'(dmem_be), 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h5A5A5A5A);
        chk("sb_hold",  32'(mem_hold), 32'h0);
        step();
        set_store(3'b100, 32'h200, 32'hCAFE0001);
        @(negedge clk);
        chk("sw_be",    32'(dmem_be), 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hCAFE0001);
        chk("sw_addr",  dmem_addr, 32'h200);
        chk("sw_hold",  32'(mem_hold), 32'h0);
        step();
        dmem_gnt = 1'b0;

        // Misaligned LW at 0x101.
        set_load(5'b00100, 32'h101, 5'd7);
        @(negedge clk);
        chk("mis_req",  32'(dmem_req), 32'h0);
        chk("mis_hold", 32'(mem_hold), 32'h0);
        step();
        chk("mis_exc",  32'(misalign_exc), 32'h1);
        chk("mis_addr", misalign_addr, 32'h101);
        chk("mis_rw",   32'(MEM_WB_regwrite), 32'h0);
        nop(32'h0);
        step();
        chk("mis_pulse", 32'(misalign_exc), 32'h0);

        // Result priority: div over mul over alu.
        nop(32'h3333);
        EX_MEM_regwrite  = 1'b1;
        EX_MEM_rd        = 5'd3;
        EX_MEM_divres    = 32'h1111;
        EX_MEM_mulres    = 32'h2222;
        EX_MEM_div_ready = 1'b1;
        EX_MEM_mul_ready = 1'b1;
        step();
        chk("sel_div", WB_res, 32'h1111);
        EX_MEM_div_ready = 1'b0;
        step();
        chk("sel_mul", WB_res, 32'h2222);
        EX_MEM_mul_ready = 1'b0;
        step();
        chk("sel_alu", WB_res, 32'h3333);

        // Debug freeze while a load waits for rvalid.
        set_load(5'b00100, 32'h104, 5'd9);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        dbg      = 1'b1;
        @(negedge clk);
        chk("dbg_hold", 32'(mem_hold), 32'h1);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        step();
        dmem_rvalid = 1'b0;
        chk("dbg_res_held", WB_res, 32'h3333);
        chk("dbg_rw_held",  32'(MEM_WB_regwrite), 32'h0);
        chk("dbg_rd_held",  32'(MEM_WB_rd), 32'd3);
        step();
        dbg = 1'b0;
        @(negedge clk);
        chk("dbg_noreq", 32'(dmem_req), 32'h0);
        chk("dbg_nohold", 32'(mem_hold), 32'h0);
        step();
        chk("dbg_res", WB_res, 32'hCAFEF00D);
        chk("dbg_rw",  32'(MEM_WB_regwrite), 32'h1);
        chk("dbg_rd",  32'(MEM_WB_rd), 32'd9);
        nop(32'h0);
        @(negedge clk);
        chk("dbg_after_req", 32'(dmem_req), 32'h0);

        // Reset while in WAIT, then a late rvalid.
        set_load(5'b00100, 32'h108, 5'd11);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        #2;
        Rst = 1'b0;
        #1;
        chk("rw_res",  WB_res, 32'h0);
        chk("rw_rw",   32'(MEM_WB_regwrite), 32'h0);
        chk("rw_rd",   32'(MEM_WB_rd), 32'h0);
        chk("rw_req",  32'(dmem_req), 32'h0);
        chk("rw_hold", 32'(mem_hold), 32'h0);
        nop(32'h0);
        @(negedge clk);
        Rst = 1'b1;
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55AA55AA;
        @(negedge clk);
        chk("late_hold", 32'(mem_hold), 32'h0);
        step();
        dmem_rvalid = 1'b0;
        chk("late_rw",  32'(MEM_WB_regwrite), 32'h0);
        chk("late_res", WB_res, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage of the RISC-V core and the consumer of the EX/MEM pipeline register written by the execute stage. It issues loads and stores to data memory over a req/gnt/rvalid handshake and generates `mem_hold` to freeze the upstream pipeline while a transaction is outstanding. It also performs byte/halfword alignment and extension, detects misaligned accesses, selects the write-back result, and loads the MEM/WB register.

## Interface
- No parameters; XLEN fixed at 32.
- `clk  in  1` system clock.
- `Rst  in  1` reset; asynchronous, active-low.
- `dbg  in  1` debug freeze; when high, the MEM/WB register holds and no new request is issued.
- `EX_MEM_memread`, `EX_MEM_memwrite`, `EX_MEM_regwrite`  in  1 each; EX/MEM control bits.
- `EX_MEM_rd  in  5` destination register.
- `EX_MEM_alures  in  32` ALU/FPU result; also the memory byte address.
- `EX_MEM_mulres`, `EX_MEM_divres`  in  32 each; multiplier and divider results.
- `EX_MEM_mul_ready`, `EX_MEM_div_ready`  in  1 each; select mulres/divres.
- `EX_MEM_dout_rs2  in  32` store data.
- `EX_MEM_loadcntrl  in  5` one-hot: [0] LB, [1] LH, [2] LW, [3] LBU, [4] LHU.
- `EX_MEM_storecntrl  in  3` one-hot: [0] SB, [1] SH, [2] SW.
- `dmem_req  out  1` request valid.
- `dmem_we  out  1` 1 = store.
- `dmem_addr  out  32` word address, {alures[31:2], 2'b00}.
- `dmem_be  out  4` byte enables.
- `dmem_wdata  out  32` store data.
- `dmem_gnt  in  1` request accepted.
- `dmem_rvalid  in  1` load data valid; arrives at least 1 cycle after gnt.
- `dmem_rdata  in  32` load data.
- `mem_hold  out  1` combinational; freezes the IF/ID/EX registers.
- `MEM_WB_rd  out  5`, `MEM_WB_regwrite  out  1`, `WB_res  out  32`; registered outputs.
- `misalign_exc  out  1` 1-cycle pulse on a misaligned access.
- `misalign_addr  out  32` faulting byte address.

## Operation
- `memop = EX_MEM_memread | EX_MEM_memwrite`.
- `misal` is true when either condition holds:
  - (LH|LHU|SH) and addr[0];
  - (LW|SW) and addr[1:0] != 0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: if memop & !misal & !dbg, assert `dmem_req`. On gnt, go to DONE-check for a store, or to WAIT for a load. Without gnt, go to REQ.
  - REQ: hold `dmem_req` and all request fields until gnt. On gnt, go to WAIT (load) or complete (store).
  - WAIT: on rvalid, capture extended load data and complete.
  - Completion: go to IDLE if !dbg, else go to DONE.
  - DONE: holds the captured data; go to IDLE when dbg falls.
- `mem_hold` is high when a memop is pending and it is not completing this cycle:
  - IDLE & memop & !misal & !(store & gnt) → high;
  - REQ & !(store & gnt) → high;
  - WAIT & !rvalid → high;
  - DONE and all other cases → low.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, be = 4'b0011 << {addr[1],1'b0}.
  - SW: wdata = rs2, be = 4'hF.
- Load extension:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- WB_res priority:
  1. memread → load data;
  2. div_ready → divres;
  3. mul_ready → mulres;
  4. otherwise alures.
- Misaligned access:
  - no dmem request and no hold;
  - MEM_WB_regwrite forced to 0;
  - `misalign_exc` pulses for 1 cycle and `misalign_addr` = alures.

## Timing
- Reset (Rst low, asynchronous):
  - FSM → IDLE;
  - MEM_WB_rd = 0, MEM_WB_regwrite = 0, WB_res = 0;
  - misalign_exc = 0, misalign_addr = 0;
  - captured load data = 0.
  - dmem_req, dmem_we, dmem_be and dmem_wdata are 0 while in reset.
  - Reset mid-transaction abandons it; a late rvalid after reset is ignored in IDLE.
- MEM/WB update at posedge:
  - if dbg: hold all outputs;
  - else if mem_hold: MEM_WB_regwrite <= 0 (bubble), rd and res unchanged;
  - else: rd <= EX_MEM_rd, regwrite <= EX_MEM_regwrite & !misal, WB_res <= selected result.
- Latency with zero-wait memory (gnt in the request cycle, rvalid next cycle):
  - store: 0 hold cycles;
  - load: 1 hold cycle; the result is in MEM_WB one edge after rvalid.
- Each cycle of gnt or rvalid delay adds exactly one hold cycle.
- `dmem_req` must not drop before gnt, and request fields must stay stable while req is high. The EX/MEM freeze guarantees this.
- gnt and rvalid outside REQ, IDLE-issue or WAIT are ignored.
- Back-to-back memops: the next request issues in the cycle after completion.

## Test plan
- LW at addr 0x100; memory returns 0xDEADBEEF with gnt in the same cycle and rvalid one cycle later → mem_hold high for exactly 1 cycle, then WB_res = 0xDEADBEEF with MEM_WB_regwrite = 1.
- LB at 0x103 with rdata 0x80112233 → dmem_addr = 0x100, WB_res = 0xFFFFFF80. LBU on the same access → WB_res = 0x00000080.
- SH of rs2 = 0x0000ABCD at 0x102 with gnt delayed 3 cycles → req held 4 cycles, be = 4'b1100, wdata = 0xABCDABCD, mem_hold high for 3 cycles.
- LW at 0x101 → no dmem_req, no hold, misalign_exc single pulse, misalign_addr = 0x101, MEM_WB_regwrite = 0.
- Load in WAIT, dbg raised before rvalid → data captured, FSM in DONE, MEM_WB unchanged. Drop dbg → WB_res updates at the next edge with no second request.
- Rst low while in WAIT → all outputs 0 immediately. A late rvalid after reset release causes no write-back.
